seq_div: RTL and testbench
==========================

# seq_div

Multi-cycle radix-2 restoring divider that acts as the responder on the operand/result stream handshake that the EXE stage drives for DIV/MOD. It accepts a dividend and a divisor on two stream slave channels and returns {quotient, remainder} on a stream master channel after a fixed latency. One instance is built per signedness: SIGNED=1 serves div.w/mod.w, SIGNED=0 serves div.wu/mod.wu. It replaces the vendor divider IP with portable RTL.

## Interface
- WIDTH, 32, operand width; result bus is 2*WIDTH.
- SIGNED, 1, 1 = two's-complement division, 0 = unsigned.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_dividend_tdata  in  WIDTH  dividend.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend ready.
- s_axis_divisor_tdata  in  WIDTH  divisor.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor ready.
- m_axis_dout_tdata  out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}.
- m_axis_dout_tvalid  out  1  result valid, one-cycle pulse, no tready.
- flush  in  1  abort; present only with SEQ_DIV_FLUSH_EN.

## Operation
- States: IDLE, CALC.
- Both treadys = (state==IDLE) & ~reset and are always equal.
- Accept when IDLE, reset low, and both tvalid high in the same cycle. A single tvalid high alone is ignored; there is no per-channel buffering.
- On accept, latch the operand magnitudes, the sign of the dividend and sign_q = dividend sign XOR divisor sign (SIGNED=1), load count=0, and enter CALC.
- CALC performs one step per cycle: shift the partial remainder left by 1 and bring in the next dividend bit from the MSB down. Subtract the divisor in WIDTH+1 bits. If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise keep the remainder and set the bit to 0.
- After WIDTH steps: quotient is negated if sign_q; remainder is negated if the dividend was negative. Register dout, pulse tvalid, return to IDLE.
- Divisor==0 overrides the result: quotient = all ones, remainder = raw dividend, for both SIGNED values.
- Signed overflow is handled by the normal datapath with no special case: most-negative / -1 gives quotient = most-negative, remainder = 0.
- m_axis_dout_tdata holds its value until the next result is registered.

## Timing
- Cycle 0 is the accept cycle. CALC spans cycles 1..WIDTH. tvalid is high only in cycle WIDTH+1 (33 for WIDTH=32). Latency is fixed and does not depend on the data.
- tready is high again in cycle WIDTH+1. A new accept in that same cycle is legal, so the maximum issue rate is one division per WIDTH+1 cycles.
- Reset values: state IDLE, count 0, m_axis_dout_tvalid 0, m_axis_dout_tdata 0, both treadys 0 while reset is high.
- Reset during CALC: the next cycle is IDLE, with no tvalid pulse and dout = 0.
- Operand tdata is sampled only in cycle 0. Changes to it afterwards have no effect.

## Configuration
- Macro: SEQ_DIV_FLUSH_EN.
- Defined: the flush port exists. If flush is high in CALC, the next cycle is IDLE with no tvalid pulse and dout unchanged. If flush is high in IDLE, an accept in that same cycle is suppressed; flush has priority over accept.
- Undefined: no flush port. Every accepted operation completes and produces exactly one tvalid pulse.

## Structure
- Shared package seq_div_pkg holds:
  - the state enum (IDLE, CALC);
  - the default WIDTH constant;
  - a localparam for count width, $clog2(WIDTH+1).
- One combinational sub-module, seq_div_step, computes one shift-subtract iteration: inputs are partial remainder, divisor and next dividend bit; outputs are the new remainder and the quotient bit. seq_div instantiates it once.

## Test plan
- Unsigned (SIGNED=0): 100/7 accepted in cycle 0 -> tvalid only in cycle 33, dout = {0x0000000E, 0x00000002}; treadys low in cycles 1..32.
- Signed: -7/2 (0xFFFFFFF9 / 0x00000002) -> dout = {0xFFFFFFFD, 0xFFFFFFFF}. Also 7/-2 -> {0xFFFFFFFD, 0x00000001}.
- Edge values:
  - 5/0 -> {0xFFFFFFFF, 0x00000005} for both SIGNED values;
  - signed 0x80000000/0xFFFFFFFF -> {0x80000000, 0x00000000}.
- Handshake:
  - dividend tvalid alone for 10 cycles -> no accept, no tvalid;
  - then both high -> accept;
  - second operation 9/4 accepted in the first's tvalid cycle -> second result {2,1} pulses exactly 33 cycles later, with exactly one pulse per operation.
- Reset asserted in cycle 10 of CALC -> no tvalid pulse, dout = 0; the next division completes correctly.
- With SEQ_DIV_FLUSH_EN: flush in cycle 5 -> no tvalid pulse, tready high next cycle, dout still holds the previous result.

Source files
------------

// File: rtl/seq_div_pkg.sv
// seq_div shared types and constants.
// Optional flush port: SEQ_DIV_FLUSH_EN.
package seq_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one restoring shift-subtract iteration.
// Optional flush port (top only): SEQ_DIV_FLUSH_EN.
import seq_div_pkg::*;

module seq_div_step #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shf;
  logic [WIDTH:0] diff;

  // Trial subtract; the W+1 bit MSB is the borrow since rem < dvs.
  always_comb begin
    shf   = {rem_i, bit_i};
    diff  = shf - {1'b0, dvs_i};
    q_o   = ~diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : shf[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: fixed-latency radix-2 restoring divider.
// Optional flush port: SEQ_DIV_FLUSH_EN.
import seq_div_pkg::*;

module seq_div #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SEQ_DIV_FLUSH_EN
  input  logic               flush,
`endif
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   raw_q, raw_d;
  logic               ndvd_q, ndvd_d;
  logic               sgn_q, sgn_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               vld_q, vld_d;

  logic               flush_w;
  logic               ready;
  logic               accept;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   q_raw;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;
  logic               a_neg;
  logic               b_neg;

`ifdef SEQ_DIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign ready  = (state_q == IDLE) & ~reset;
  assign accept = ready & s_axis_dividend_tvalid
                & s_axis_divisor_tvalid & ~flush_w;

  assign s_axis_dividend_tready = ready;
  assign s_axis_divisor_tready  = ready;
  assign m_axis_dout_tdata      = dout_q;
  assign m_axis_dout_tvalid     = vld_q;

  seq_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (dvd_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Operand signs and final sign correction of the last step.
  always_comb begin
    a_neg = SIGNED & s_axis_dividend_tdata[WIDTH-1];
    b_neg = SIGNED & s_axis_divisor_tdata[WIDTH-1];
    q_raw = {quo_q[WIDTH-2:0], step_q};
    q_fin = sgn_q ? -q_raw : q_raw;
    r_fin = ndvd_q ? -step_rem : step_rem;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    raw_d   = raw_q;
    ndvd_d  = ndvd_q;
    sgn_d   = sgn_q;
    zero_d  = zero_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          cnt_d   = '0;
          dvd_d   = a_neg ? -s_axis_dividend_tdata
                          : s_axis_dividend_tdata;
          dvs_d   = b_neg ? -s_axis_divisor_tdata
                          : s_axis_divisor_tdata;
          rem_d   = '0;
          quo_d   = '0;
          raw_d   = s_axis_dividend_tdata;
          ndvd_d  = a_neg;
          sgn_d   = a_neg ^ b_neg;
          zero_d  = (s_axis_divisor_tdata == '0);
        end
      end
      CALC: begin
        if (flush_w) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          rem_d = step_rem;
          quo_d = q_raw;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            vld_d   = 1'b1;
            dout_d  = zero_q ? {{WIDTH{1'b1}}, raw_q}
                             : {q_fin, r_fin};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      raw_q   <= '0;
      ndvd_q  <= 1'b0;
      sgn_q   <= 1'b0;
      zero_q  <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      raw_q   <= raw_d;
      ndvd_q  <= ndvd_d;
      sgn_q   <= sgn_d;
      zero_q  <= zero_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed checks of signed and unsigned seq_div.
// Flush checks are built when SEQ_DIV_FLUSH_EN is defined.
module tb_seq_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] a, b;
  logic        a_vld, b_vld;
  logic        s_ard, s_brd, u_ard, u_brd;
  logic [63:0] s_dout, u_dout;
  logic        s_vld, u_vld;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_div #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
    .clk                    (clk),
    .reset                  (reset),
`ifdef SEQ_DIV_FLUSH_EN
    .flush                  (flush),
`endif
    .s_axis_dividend_tdata  (a),
    .s_axis_dividend_tvalid (a_vld),
    .s_axis_dividend_tready (s_ard),
    .s_axis_divisor_tdata   (b),
    .s_axis_divisor_tvalid  (b_vld),
    .s_axis_divisor_tready  (s_brd),
    .m_axis_dout_tdata      (s_dout),
    .m_axis_dout_tvalid     (s_vld)
  );

  seq_div #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
    .clk                    (clk),
    .reset                  (reset),
`ifdef SEQ_DIV_FLUSH_EN
    .flush                  (flush),
`endif
    .s_axis_dividend_tdata  (a),
    .s_axis_dividend_tvalid (a_vld),
    .s_axis_dividend_tready (u_ard),
    .s_axis_divisor_tdata   (b),
    .s_axis_divisor_tvalid  (b_vld),
    .s_axis_divisor_tready  (u_brd),
    .m_axis_dout_tdata      (u_dout),
    .m_axis_dout_tvalid     (u_vld)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue in the current cycle (cycle 0), then check cycles 1..33.
  task automatic run_op(input string tag,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] es, input logic [63:0] eu);
    logic quiet;
    chk({tag, "_rdy0"}, {s_ard, s_brd, u_ard, u_brd}, 64'hF);
    a = x; b = y; a_vld = 1'b1; b_vld = 1'b1;
    quiet = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 1) begin
        a = 32'hDEAD_BEEF; b = 32'h0000_0003;
        a_vld = 1'b0; b_vld = 1'b0;
      end
      if (s_vld || u_vld || s_ard || s_brd || u_ard || u_brd)
        quiet = 1'b0;
    end
    chk({tag, "_busy"}, {63'd0, quiet}, 64'd1);
    tick();
    chk({tag, "_vld"}, {62'd0, s_vld, u_vld}, 64'd3);
    chk({tag, "_s"}, s_dout, es);
    chk({tag, "_u"}, u_dout, eu);
  endtask

  initial begin
    logic quiet;
    reset = 1'b1; flush = 1'b0;
    a = '0; b = '0; a_vld = 1'b0; b_vld = 1'b0;
    tick(); tick();
    chk("rst_rdy", {s_ard, s_brd, u_ard, u_brd}, 64'h0);
    chk("rst_vld", {62'd0, s_vld, u_vld}, 64'd0);
    chk("rst_dout", s_dout | u_dout, 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_rdy", {s_ard, s_brd, u_ard, u_brd}, 64'hF);

    // Dividend valid alone must not be accepted.
    a = 32'd100; b = 32'd7; a_vld = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_vld || u_vld || !s_ard || !u_ard) quiet = 1'b0;
    end
    chk("solo_noacc", {63'd0, quiet}, 64'd1);
    a_vld = 1'b0;

    run_op("u100_7", 32'd100, 32'd7,
           {32'h0000_000E, 32'h0000_0002},
           {32'h0000_000E, 32'h0000_0002});
    // Back-to-back accept in the result cycle.
    run_op("b2b_9_4", 32'd9, 32'd4,
           {32'h0000_0002, 32'h0000_0001},
           {32'h0000_0002, 32'h0000_0001});
    tick();
    chk("one_pulse", {62'd0, s_vld, u_vld}, 64'd0);

    run_op("m7_2", 32'hFFFF_FFF9, 32'h0000_0002,
           {32'hFFFF_FFFD, 32'hFFFF_FFFF},
           {32'h7FFF_FFFC, 32'h0000_0001});
    run_op("7_m2", 32'h0000_0007, 32'hFFFF_FFFE,
           {32'hFFFF_FFFD, 32'h0000_0001},
           {32'h0000_0000, 32'h0000_0007});
    run_op("5_0", 32'd5, 32'd0,
           {32'hFFFF_FFFF, 32'h0000_0005},
           {32'hFFFF_FFFF, 32'h0000_0005});
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF,
           {32'h8000_0000, 32'h0000_0000},
           {32'h0000_0000, 32'h8000_0000});
    tick();

    // Reset in cycle 10 of CALC.
    a = 32'd100; b = 32'd7; a_vld = 1'b1; b_vld = 1'b1;
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_rdy", {s_ard, s_brd, u_ard, u_brd}, 64'hF);
    chk("mid_rst_dout", s_dout | u_dout, 64'd0);
    quiet = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (s_vld || u_vld) quiet = 1'b0;
    end
    chk("mid_rst_nopulse", {63'd0, quiet}, 64'd1);
    run_op("post_rst", 32'd9, 32'd4,
           {32'h0000_0002, 32'h0000_0001},
           {32'h0000_0002, 32'h0000_0001});
    tick();

`ifdef SEQ_DIV_FLUSH_EN
    // Flush in cycle 5 of CALC.
    a = 32'd100; b = 32'd7; a_vld = 1'b1; b_vld = 1'b1;
    tick();
    a_vld = 1'b0; b_vld = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_rdy", {s_ard, s_brd, u_ard, u_brd}, 64'hF);
    chk("fl_dout", s_dout, {32'h0000_0002, 32'h0000_0001});
    quiet = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (s_vld || u_vld) quiet = 1'b0;
    end
    chk("fl_nopulse", {63'd0, quiet}, 64'd1);
    // Flush in IDLE beats a same-cycle accept.
    flush = 1'b1; a_vld = 1'b1; b_vld = 1'b1;
    tick();
    flush = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
    #1;
    chk("fl_idle", {s_ard, s_brd, u_ard, u_brd}, 64'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
